// File: rtl/simplebus_pkg.sv
// simplebus_pkg: shared definitions for the Wishbone-to-simplebus master.
//   - command byte values exchanged on the 8-bit external bus
//   - frame byte counts and the width of the outbound frame shift register
//   - FSM state encoding
//   - odd-parity helper used to validate bytes coming back from the slave
package simplebus_pkg;

    localparam logic [7:0] CMD_READ      = 8'h02;
    localparam logic [7:0] CMD_WRITE     = 8'h03;
    localparam logic [7:0] CMD_READ_ACK  = 8'h82;
    localparam logic [7:0] CMD_WRITE_ACK = 8'h83;

    localparam int ADDR_BYTES        = 4;
    localparam int DATA_BYTES        = 8;
    // Read: cmd + address. Write: cmd + address + sel + data.
    localparam int READ_FRAME_BYTES  = 1 + ADDR_BYTES;
    localparam int WRITE_FRAME_BYTES = 1 + ADDR_BYTES + 1 + DATA_BYTES;
    localparam int FRAME_BITS        = 8 * WRITE_FRAME_BYTES;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT_ACK,
        ST_RECV,
        ST_DONE
    } state_t;

    // Bus parity is odd: the parity bit makes the total count of ones odd.
    function automatic logic parity_ok(input logic [7:0] data, input logic pty);
        return pty == ~^data;
    endfunction

endpackage

// File: rtl/simplebus_clkgen.sv
// simplebus_clkgen: free-running bus clock divider.
//   clk      in   system clock
//   rst      in   asynchronous active-high reset (bus_clk forced low)
//   bus_clk  out  clk / (2*HALF_PERIOD)
//   rise_stb out  high during the clk cycle whose closing edge raises bus_clk
//   fall_stb out  high during the clk cycle whose closing edge lowers bus_clk
// The strobes are combinational so that logic clocked by clk acts on exactly
// the same edge that moves bus_clk.
module simplebus_clkgen #(
    parameter int HALF_PERIOD = 1
) (
    input  logic clk,
    input  logic rst,
    output logic bus_clk,
    output logic rise_stb,
    output logic fall_stb
);

    logic [3:0] div_reg;
    logic       edge_now;

    assign edge_now = (div_reg == 4'(HALF_PERIOD - 1));
    assign rise_stb = edge_now & ~bus_clk;
    assign fall_stb = edge_now &  bus_clk;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_reg <= '0;
            bus_clk <= 1'b0;
        end else if (edge_now) begin
            div_reg <= '0;
            bus_clk <= ~bus_clk;
        end else begin
            div_reg <= div_reg + 4'd1;
        end
    end

endmodule

// File: rtl/simplebus_master.sv
// simplebus_master: bridges single 64-bit Wishbone transfers onto the 8-bit
// parity-protected simplebus and completes the Wishbone cycle when the slave
// acknowledges.
//   clk, rst                     system clock, asynchronous active-high reset
//   wb_adr/wb_dat_w/wb_sel/wb_we Wishbone request (doubleword address)
//   wb_cyc, wb_stb               Wishbone request qualifiers
//   wb_dat_r                     read data (all ones after an error)
//   wb_ack                       one-clk completion pulse
//   wb_stall                     high while a transfer is in flight
//   bus_clk, bus_out, bus_pty_out outbound bus (bus_out moves on bus_clk fall)
//   bus_in, bus_pty_in           inbound bus (sampled on bus_clk rise)
//   err                          sticky parity/protocol/timeout flag
module simplebus_master
    import simplebus_pkg::*;
#(
    parameter int HALF_PERIOD = 1,
    parameter int TIMEOUT     = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [28:0] wb_adr,
    input  logic [63:0] wb_dat_w,
    input  logic [7:0]  wb_sel,
    input  logic        wb_we,
    input  logic        wb_cyc,
    input  logic        wb_stb,
    output logic [63:0] wb_dat_r,
    output logic        wb_ack,
    output logic        wb_stall,
    output logic        bus_clk,
    output logic [7:0]  bus_out,
    output logic        bus_pty_out,
    input  logic [7:0]  bus_in,
    input  logic        bus_pty_in,
    output logic        err
);

    localparam int TMO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    state_t                  state_reg;
    logic [FRAME_BITS-1:0]   frame_reg;
    logic [3:0]              byte_cnt_reg;
    logic                    we_reg;
    logic [TMO_W-1:0]        tmo_reg;
    logic [63:0]             rx_reg;
    logic [3:0]              rx_cnt_reg;
    logic                    perr_reg;

    logic                    rise_stb;
    logic                    fall_stb;
    logic                    byte_ok;
    logic [7:0]              ack_cmd;
    logic [63:0]             rx_next;
    logic [31:0]             byte_adr;

    simplebus_clkgen #(
        .HALF_PERIOD(HALF_PERIOD)
    ) u_clkgen (
        .clk      (clk),
        .rst      (rst),
        .bus_clk  (bus_clk),
        .rise_stb (rise_stb),
        .fall_stb (fall_stb)
    );

    assign bus_pty_out = ~^bus_out;
    assign byte_ok     = parity_ok(bus_in, bus_pty_in);
    assign ack_cmd     = we_reg ? CMD_WRITE_ACK : CMD_READ_ACK;
    assign rx_next     = {bus_in, rx_reg[63:8]};
    assign byte_adr    = {wb_adr, 3'b000};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            frame_reg    <= '0;
            byte_cnt_reg <= '0;
            we_reg       <= 1'b0;
            tmo_reg      <= '0;
            rx_reg       <= '0;
            rx_cnt_reg   <= '0;
            perr_reg     <= 1'b0;
            wb_dat_r     <= '0;
            wb_ack       <= 1'b0;
            wb_stall     <= 1'b0;
            bus_out      <= '0;
            err          <= 1'b0;
        end else begin
            wb_ack <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (wb_cyc && wb_stb) begin
                        we_reg    <= wb_we;
                        // Byte 0 of the frame sits in the low byte and is
                        // shifted out first, giving LSB-first fields.
                        frame_reg <= wb_we
                            ? FRAME_BITS'({wb_dat_w, wb_sel, byte_adr, CMD_WRITE})
                            : FRAME_BITS'({byte_adr, CMD_READ});
                        byte_cnt_reg <= wb_we ? 4'(WRITE_FRAME_BYTES)
                                              : 4'(READ_FRAME_BYTES);
                        wb_stall  <= 1'b1;
                        state_reg <= ST_SEND;
                    end
                end

                ST_SEND: begin
                    if (fall_stb) begin
                        if (byte_cnt_reg != 4'd0) begin
                            bus_out      <= frame_reg[7:0];
                            frame_reg    <= frame_reg >> 8;
                            byte_cnt_reg <= byte_cnt_reg - 4'd1;
                        end else begin
                            // The fall after the last byte returns the bus to
                            // idle; the slave's reply is sampled from the next rise.
                            bus_out   <= 8'h00;
                            tmo_reg   <= TMO_W'(TIMEOUT);
                            state_reg <= ST_WAIT_ACK;
                        end
                    end
                end

                ST_WAIT_ACK: begin
                    if (rise_stb) begin
                        if (!byte_ok
                            || (bus_in != 8'h00 && bus_in != ack_cmd)
                            || (bus_in == 8'h00 && tmo_reg <= TMO_W'(1))) begin
                            err       <= 1'b1;
                            wb_dat_r  <= '1;
                            state_reg <= ST_DONE;
                        end else if (bus_in == 8'h00) begin
                            tmo_reg <= tmo_reg - TMO_W'(1);
                        end else if (we_reg) begin
                            state_reg <= ST_DONE;
                        end else begin
                            rx_cnt_reg <= 4'(DATA_BYTES);
                            perr_reg   <= 1'b0;
                            state_reg  <= ST_RECV;
                        end
                    end
                end

                ST_RECV: begin
                    // A bad data byte is remembered rather than acted on at
                    // once so the slave's data phase always runs to the end
                    // and the bus is idle again when the cycle completes.
                    if (rise_stb) begin
                        rx_reg     <= rx_next;
                        rx_cnt_reg <= rx_cnt_reg - 4'd1;
                        if (!byte_ok) begin
                            perr_reg <= 1'b1;
                        end
                        if (rx_cnt_reg == 4'd1) begin
                            state_reg <= ST_DONE;
                            if (perr_reg || !byte_ok) begin
                                err      <= 1'b1;
                                wb_dat_r <= '1;
                            end else begin
                                wb_dat_r <= rx_next;
                            end
                        end
                    end
                end

                ST_DONE: begin
                    wb_ack    <= 1'b1;
                    wb_stall  <= 1'b0;
                    state_reg <= ST_IDLE;
                end

                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_simplebus_master.sv
// tb_simplebus_master: directed test of simplebus_master with a slave model
// on the external bus and a scoreboard that checks every Wishbone completion.
// A second instance with TIMEOUT=4 is used for the timeout case only.
module tb_simplebus_master;

    localparam int HP        = 2;
    localparam int TMO_SHORT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [28:0] wb_adr = '0;
    logic [63:0] wb_dat_w = '0;
    logic [7:0]  wb_sel = '0;
    logic        wb_we = 1'b0;
    logic        wb_cyc = 1'b0;
    logic        wb_stb = 1'b0;
    logic [7:0]  bus_in;
    logic        bus_pty_in;
    logic        to_mode = 1'b0;

    logic        cyc_m, cyc_t;
    logic [63:0] m_dat_r, t_dat_r, dat_r;
    logic        m_ack, t_ack, ack;
    logic        m_stall, t_stall, stall;
    logic        m_bclk, t_bclk, bclk;
    logic [7:0]  m_bout, t_bout, bout;
    logic        m_bpty, t_bpty, bpty;
    logic        m_err, t_err, err;

    assign cyc_m = wb_cyc & ~to_mode;
    assign cyc_t = wb_cyc &  to_mode;
    assign dat_r = to_mode ? t_dat_r : m_dat_r;
    assign ack   = to_mode ? t_ack   : m_ack;
    assign stall = to_mode ? t_stall : m_stall;
    assign bclk  = to_mode ? t_bclk  : m_bclk;
    assign bout  = to_mode ? t_bout  : m_bout;
    assign bpty  = to_mode ? t_bpty  : m_bpty;
    assign err   = to_mode ? t_err   : m_err;

    simplebus_master #(.HALF_PERIOD(HP), .TIMEOUT(255)) dut (
        .clk(clk), .rst(rst), .wb_adr(wb_adr), .wb_dat_w(wb_dat_w),
        .wb_sel(wb_sel), .wb_we(wb_we), .wb_cyc(cyc_m), .wb_stb(wb_stb),
        .wb_dat_r(m_dat_r), .wb_ack(m_ack), .wb_stall(m_stall),
        .bus_clk(m_bclk), .bus_out(m_bout), .bus_pty_out(m_bpty),
        .bus_in(bus_in), .bus_pty_in(bus_pty_in), .err(m_err)
    );

    simplebus_master #(.HALF_PERIOD(HP), .TIMEOUT(TMO_SHORT)) dut_to (
        .clk(clk), .rst(rst), .wb_adr(wb_adr), .wb_dat_w(wb_dat_w),
        .wb_sel(wb_sel), .wb_we(wb_we), .wb_cyc(cyc_t), .wb_stb(wb_stb),
        .wb_dat_r(t_dat_r), .wb_ack(t_ack), .wb_stall(t_stall),
        .bus_clk(t_bclk), .bus_out(t_bout), .bus_pty_out(t_bpty),
        .bus_in(bus_in), .bus_pty_in(bus_pty_in), .err(t_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] dat;
        logic        err;
        bit          full;
        int          tag;
    } exp_t;

    typedef struct {
        bit          silent;
        int          delay;
        logic [7:0]  ackb;
        bit          has_data;
        logic [63:0] data;
        int          bad_idx;
        int          exp_rises;
    } resp_t;

    typedef struct {
        logic [111:0] bytes;
        int           len;
    } frame_t;

    exp_t   exp_q[$];
    resp_t  resp_q[$];
    frame_t frame_q[$];

    int n_vec = 0;
    int n_bad = 0;
    int tag_cnt = 0;
    int rst_count = 0;
    int rst_seen = 0;
    int resp_data_sent = 0;
    int cap_n = 0;

    task automatic check(input string name, input logic [111:0] act, input logic [111:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    function automatic resp_t mk_resp(input bit silent, input int delay, input logic [7:0] ackb,
                                      input bit has_data, input logic [63:0] data,
                                      input int bad_idx, input int exp_rises);
        resp_t r;
        r.silent = silent; r.delay = delay; r.ackb = ackb; r.has_data = has_data;
        r.data = data; r.bad_idx = bad_idx; r.exp_rises = exp_rises;
        return r;
    endfunction

    task automatic expect_txn(input logic [111:0] fb, input int flen, input resp_t r,
                              input logic [63:0] dat, input logic e, input bit full);
        frame_t f;
        exp_t   x;
        f.bytes = fb; f.len = flen;
        x.dat = dat; x.err = e; x.full = full; x.tag = tag_cnt;
        tag_cnt++;
        frame_q.push_back(f);
        resp_q.push_back(r);
        exp_q.push_back(x);
    endtask

    // ---------------- scoreboard monitor ----------------
    logic prev_ack = 1'b0;
    always @(negedge clk) begin
        if (ack) begin
            check("ack_one_clk", prev_ack, 1'b0);
            check("stall_at_ack", stall, 1'b0);
            if (exp_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_ack: got ack, expected none (dat_r=%h)", dat_r);
            end else begin
                exp_t x;
                x = exp_q.pop_front();
                check($sformatf("txn%0d_dat_r", x.tag), dat_r, x.dat);
                check($sformatf("txn%0d_err", x.tag), err, x.err);
                $display("txn%0d ack: dat_r=%h err=%0b", x.tag, dat_r, err);
                if (x.full)
                    check($sformatf("txn%0d_data_bytes_before_ack", x.tag), resp_data_sent, 8);
            end
        end
        prev_ack = ack;
    end

    // ---------------- slave model ----------------
    task automatic drive(input logic [7:0] b, input bit bad);
        @(negedge bclk);
        bus_in = b;
        bus_pty_in = (~^b) ^ bad;
    endtask

    task automatic play(input resp_t r);
        if (r.silent) begin
            int n = 0;
            for (int i = 0; i < 1000; i++) begin
                @(posedge bclk or posedge ack);
                if (ack) break;
                n++;
            end
            check("timeout_bus_clks", n, r.exp_rises);
        end else begin
            resp_data_sent = 0;
            for (int i = 0; i < r.delay; i++) drive(8'h00, 1'b0);
            drive(r.ackb, 1'b0);
            if (r.has_data) begin
                for (int i = 0; i < 8; i++) begin
                    drive(r.data[i*8 +: 8], i == r.bad_idx);
                    resp_data_sent++;
                end
            end
            drive(8'h00, 1'b0);
        end
    endtask

    initial begin
        logic [111:0] cap;
        int           cap_len;
        frame_t       f;
        bus_in = 8'h00;
        bus_pty_in = 1'b1;
        cap = '0;
        cap_len = 5;
        forever begin
            @(posedge bclk);
            if (rst_seen != rst_count) begin
                cap_n = 0;
                rst_seen = rst_count;
            end
            if (cap_n != 0 || bout != 8'h00) begin
                check("bus_pty_out", bpty, ~^bout);
                if (cap_n == 0) begin
                    cap_len = (bout == 8'h03) ? 14 : 5;
                    cap = '0;
                end
                cap[cap_n*8 +: 8] = bout;
                cap_n++;
                if (cap_n == cap_len) begin
                    cap_n = 0;
                    if (frame_q.size() == 0) begin
                        n_vec++;
                        n_bad++;
                        $display("FAIL unexpected_frame: got %h, expected none", cap);
                    end else begin
                        f = frame_q.pop_front();
                        check("frame_len", cap_len, f.len);
                        check("frame_bytes", cap, f.bytes);
                        $display("frame len=%0d bytes=%h", cap_len, cap);
                    end
                    if (resp_q.size() != 0) play(resp_q.pop_front());
                end
            end
        end
    end

    // ---------------- Wishbone driver ----------------
    task automatic wb_issue(input logic we, input logic [28:0] adr,
                            input logic [63:0] dat, input logic [7:0] sel);
        int i;
        @(negedge clk);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we;
        wb_adr = adr; wb_dat_w = dat; wb_sel = sel;
        i = 0;
        while (stall && i < 3000) begin
            @(negedge clk);
            i++;
        end
        if (stall) check("accept_timeout", stall, 1'b0);
        @(posedge clk);
    endtask

    task automatic wb_release();
        @(negedge clk);
        wb_cyc = 1'b0;
        wb_stb = 1'b0;
    endtask

    task automatic wait_done();
        int i;
        i = 0;
        while ((exp_q.size() != 0 || frame_q.size() != 0) && i < 5000) begin
            @(negedge clk);
            i++;
        end
        check("completion_timeout", exp_q.size() + frame_q.size(), 0);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish before 500us");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    localparam logic [63:0] RD_DATA = 64'h0102030405060708;
    localparam logic [63:0] ONES    = 64'hFFFF_FFFF_FFFF_FFFF;

    initial begin
        int i;
        #1 rst = 1'b1;
        #10;
        check("rst_ack", m_ack, 1'b0);
        check("rst_stall", m_stall, 1'b0);
        check("rst_dat_r", m_dat_r, 64'h0);
        check("rst_bus_out", m_bout, 8'h00);
        check("rst_bus_clk", m_bclk, 1'b0);
        check("rst_err", m_err, 1'b0);
        check("rst_bus_pty_out", m_bpty, 1'b1);
        check("rst_to_err", t_err, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Read 0x800, slave replies after 8 idle bus clocks.
        expect_txn(112'h00_00_08_00_02, 5, mk_resp(0, 8, 8'h82, 1, RD_DATA, -1, 0),
                   RD_DATA, 1'b0, 1);
        wb_issue(1'b0, 29'h100, 64'h0, 8'hFF);
        wb_release();
        wait_done();

        // Write to byte address 0x10; read data register must be untouched.
        expect_txn(112'hDEADBEEF_CAFEF00D_0F_00000010_03, 14,
                   mk_resp(0, 2, 8'h83, 0, 64'h0, -1, 0), RD_DATA, 1'b0, 0);
        wb_issue(1'b1, 29'h2, 64'hDEADBEEF_CAFEF00D, 8'h0F);
        wb_release();
        wait_done();

        // Back-to-back reads with wb_stb held across both.
        expect_txn(112'h00_00_00_18_02, 5, mk_resp(0, 0, 8'h82, 1, 64'h1122334455667788, -1, 0),
                   64'h1122334455667788, 1'b0, 1);
        expect_txn(112'hFF_FF_FF_F8_02, 5, mk_resp(0, 3, 8'h82, 1, 64'h8000000000000001, -1, 0),
                   64'h8000000000000001, 1'b0, 1);
        wb_issue(1'b0, 29'h3, 64'h0, 8'hFF);
        wb_issue(1'b0, 29'h1FFF_FFFF, 64'h0, 8'hFF);
        wb_release();
        wait_done();

        // Reset during the write frame; nothing is expected from the write.
        wb_issue(1'b1, 29'h5, 64'h0123_4567_89AB_CDEF, 8'hFF);
        wb_release();
        i = 0;
        while (cap_n < 3 && i < 2000) begin
            @(negedge clk);
            i++;
        end
        check("mid_send_bytes_seen", cap_n >= 3, 1'b1);
        @(negedge clk);
        #2 rst = 1'b1;
        rst_count++;
        #1;
        check("midrst_bus_out", m_bout, 8'h00);
        check("midrst_stall", m_stall, 1'b0);
        check("midrst_bus_clk", m_bclk, 1'b0);
        check("midrst_ack", m_ack, 1'b0);
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        expect_txn(112'h00_00_02_00_02, 5, mk_resp(0, 1, 8'h82, 1, 64'hA5A55A5A0F0FF0F0, -1, 0),
                   64'hA5A55A5A0F0FF0F0, 1'b0, 1);
        wb_issue(1'b0, 29'h40, 64'h0, 8'hFF);
        wb_release();
        wait_done();

        // Protocol error: read answered with a write acknowledge.
        expect_txn(112'h00_00_00_38_02, 5, mk_resp(0, 1, 8'h83, 0, 64'h0, -1, 0),
                   ONES, 1'b1, 0);
        wb_issue(1'b0, 29'h7, 64'h0, 8'hFF);
        wb_release();
        wait_done();
        check("err_sticky", m_err, 1'b1);

        // Clear err for the parity case.
        @(negedge clk);
        rst = 1'b1;
        rst_count++;
        #1 check("err_cleared_by_rst", m_err, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Parity error on the third data byte: completes after all 8 bytes.
        expect_txn(112'h00_00_08_00_02, 5, mk_resp(0, 2, 8'h82, 1, RD_DATA, 2, 0),
                   ONES, 1'b1, 1);
        wb_issue(1'b0, 29'h100, 64'h0, 8'hFF);
        wb_release();
        wait_done();

        // Timeout on the TIMEOUT=4 instance with a silent slave.
        @(negedge clk);
        to_mode = 1'b1;
        expect_txn(112'h00_00_00_48_02, 5, mk_resp(1, 0, 8'h00, 0, 64'h0, -1, TMO_SHORT),
                   ONES, 1'b1, 0);
        wb_issue(1'b0, 29'h9, 64'h0, 8'hFF);
        wb_release();
        wait_done();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
